// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- handshake/status bundle between the pipeline controller
// and its environment.
//   master : drives instruction/hazard/branch/multi-cycle/halt requests,
//            observes stage enables, stage valids, fetch enable and busy.
//   slave  : the controller side (pipe_ctrl).
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int MC_CNT_W   = 4
);
  logic                  instr_valid_in;
  logic                  hazard_stall;
  logic                  branch_taken;
  logic                  mc_start;
  logic [MC_CNT_W-1:0]   mc_cycles;
  logic                  halt_req;
  logic                  resume;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  fetch_en;
  logic                  busy;

  modport master (
    output instr_valid_in, hazard_stall, branch_taken, mc_start, mc_cycles,
           halt_req, resume,
    input  stage_en, stage_valid, fetch_en, busy
  );

  modport slave (
    input  instr_valid_in, hazard_stall, branch_taken, mc_start, mc_cycles,
           halt_req, resume,
    output stage_en, stage_valid, fetch_en, busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- in-order pipeline controller.
// Generates per-stage load enables and tracks per-stage valid bits for a
// NUM_STAGES-deep pipe (stage 0 = fetch, NUM_STAGES-1 = writeback). Handles
// data-hazard stalls, branch flushes, multi-cycle EX occupancy and a
// drain-then-halt / resume sequence.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : instr_valid_in, hazard_stall, branch_taken, mc_start,
//                 mc_cycles, halt_req, resume in;
//                 stage_en, stage_valid, fetch_en, busy out
//   stall_cnt, flush_cnt : saturating event counters, present only when the
//                 macro PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int EX_STAGE   = 2,
  parameter int MC_CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);
  localparam int NS = NUM_STAGES;
  // bits 0..EX_STAGE and bits 0..EX_STAGE-1
  localparam logic [NS-1:0] UPTO_EX  = {NS{1'b1}} >> (NS - 1 - EX_STAGE);
  localparam logic [NS-1:0] BELOW_EX = {NS{1'b1}} >> (NS - EX_STAGE);

  typedef enum logic [1:0] {S_RUN, S_MC_WAIT, S_DRAIN, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                halt_pend_q, halt_pend_d;
  logic [NS-1:0]       valid_q, valid_d;

  logic [NS-1:0] en, kill, bubble;
  logic          fetch;
  logic          active, mc_take, br_take, hz_take;

  // Event arbitration: multi-cycle beats branch, branch beats hazard.
  always_comb begin
    active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    mc_take = active && bus.mc_start && valid_q[EX_STAGE] &&
              (bus.mc_cycles >= MC_CNT_W'(2));
    br_take = active && !mc_take && bus.branch_taken;
    hz_take = active && !mc_take && !br_take && bus.hazard_stall;
  end

  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    halt_pend_d = halt_pend_q;
    en          = '1;
    kill        = '0;
    bubble      = '0;
    fetch       = 1'b0;
    case (state_q)
      S_RUN, S_DRAIN: begin
        fetch = (state_q == S_RUN);
        if (mc_take) begin
          // Freeze fetch..EX, let the older stages move away from a bubble.
          en                 = ~UPTO_EX;
          bubble[EX_STAGE+1] = 1'b1;
          fetch              = 1'b0;
          mc_cnt_d           = bus.mc_cycles - MC_CNT_W'(1);
          state_d            = S_MC_WAIT;
          // A drain interrupted by a multi-cycle op resumes draining after it.
          halt_pend_d        = bus.halt_req || (state_q == S_DRAIN);
        end else begin
          if (br_take) begin
            kill = UPTO_EX;
          end else if (hz_take) begin
            en               = ~BELOW_EX;
            bubble[EX_STAGE] = 1'b1;
            fetch            = 1'b0;
          end
          if (state_q == S_DRAIN) begin
            if (valid_q == '0) state_d = S_HALTED;
          end else if (bus.halt_req) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_MC_WAIT: begin
        en                 = ~UPTO_EX;
        bubble[EX_STAGE+1] = 1'b1;
        mc_cnt_d           = mc_cnt_q - MC_CNT_W'(1);
        if (bus.halt_req) halt_pend_d = 1'b1;
        if (mc_cnt_q == MC_CNT_W'(1)) begin
          state_d     = (halt_pend_q || bus.halt_req) ? S_DRAIN : S_RUN;
          halt_pend_d = 1'b0;
        end
      end
      S_HALTED: begin
        en = '0;
        if (bus.resume) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Per-stage valid: flush/bubble force 0, enabled stages take the younger
  // neighbour's bit, disabled stages hold.
  always_comb begin
    valid_d = valid_q;
    if (kill[0] || bubble[0]) valid_d[0] = 1'b0;
    else if (en[0])           valid_d[0] = bus.instr_valid_in & fetch;
    for (int i = 1; i < NS; i++) begin
      if (kill[i] || bubble[i]) valid_d[i] = 1'b0;
      else if (en[i])           valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      mc_cnt_q    <= '0;
      halt_pend_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      halt_pend_q <= halt_pend_d;
      valid_q     <= valid_d;
    end
  end

  // Outputs are forced to their idle-run values while reset is held so the
  // datapath sees a clean pipe regardless of request inputs.
  assign bus.stage_en    = rst_n ? en : '1;
  assign bus.fetch_en    = rst_n ? fetch : 1'b1;
  assign bus.stage_valid = valid_q;
  assign bus.busy        = (state_q != S_HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != S_HALTED && !fetch && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (br_take && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule
